// File: rtl/spi_slave_mem_bridge.sv
// SPI slave bridge: framed SPI commands (8b cmd, address, data words) become
// word-wide memory writes/reads. All SPI pins are oversampled on i_clk.
// Ports: i_clk/i_rst, SPI pins (i_spi_clk, i_spi_mosi, i_spi_cs_n,
// o_spi_miso, o_spi_miso_oe), memory port (o_mem_wr_en, o_mem_rd_en,
// o_mem_addr, o_mem_wdata, i_mem_rdata), status (o_busy, o_frame_err).
// Optional feature macro: SPI_SLAVE_MISO_EN enables READ (0x03) and MISO.
module spi_slave_mem_bridge #(
  parameter int SPI_MODE   = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_mosi,
  input  logic                  i_spi_cs_n,
  output logic                  o_spi_miso,
  output logic                  o_spi_miso_oe,
  output logic                  o_mem_wr_en,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy,
  output logic                  o_frame_err
);

  localparam bit CPOL = ((SPI_MODE >> 1) & 1) != 0;
  localparam bit CPHA = (SPI_MODE & 1) != 0;
  localparam int SW   = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

  localparam logic [6:0] CMD_LAST  = 7'd7;
  localparam logic [6:0] ADDR_LAST = 7'(ADDR_WIDTH - 1);
  localparam logic [6:0] DATA_LAST = 7'(DATA_WIDTH - 1);

  localparam logic [7:0] CMD_WRITE = 8'h02;
`ifdef SPI_SLAVE_MISO_EN
  localparam logic [7:0] CMD_READ  = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WR_DATA,
    S_RD_TURN,
    S_RD_DATA,
    S_DISCARD
  } state_t;

  // [0],[1] = synchroniser, [2] = previous synchronised value
  logic [2:0] sclk_q;
  logic [2:0] csn_q;
  logic [1:0] mosi_q;

  logic       samp_q;
  logic       mbit_q;

  state_t                 state_q;
  logic [6:0]             cnt_q;
  logic [SW-1:0]          sh_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   wr_en_q;
  logic                   inc_q;
  logic                   busy_q;
  logic                   err_q;

`ifdef SPI_SLAVE_MISO_EN
  logic                   rd_en_q;
  logic                   rd_pend_q;
  logic                   is_rd_q;
  logic                   miso_q;
  logic                   shedge_q;
  logic [DATA_WIDTH-1:0]  pre_q;
`else
  logic unused_ok;
  assign unused_ok = ^{i_mem_rdata, sh_q[SW-1]};
`endif

  logic sclk_rise, sclk_fall, lead, trail, samp;
  logic cs_fall, cs_rise;
  logic [7:0]            cmd_w;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign lead      = CPOL ? sclk_fall : sclk_rise;
  assign trail     = CPOL ? sclk_rise : sclk_fall;
  assign samp      = CPHA ? trail : lead;
  assign cs_fall   = csn_q[2] & ~csn_q[1];
  assign cs_rise   = ~csn_q[2] & csn_q[1];

  assign cmd_w  = {sh_q[6:0], mbit_q};
  assign addr_w = {sh_q[ADDR_WIDTH-2:0], mbit_q};
  assign data_w = {sh_q[DATA_WIDTH-2:0], mbit_q};

  // Sync flops reset low so a CS_n held low across reset is not taken as
  // a fresh fall; a real high-then-low is needed to start a frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_q   <= '0;
      csn_q    <= '0;
      mosi_q   <= '0;
      samp_q   <= 1'b0;
      mbit_q   <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      shedge_q <= 1'b0;
`endif
    end else begin
      sclk_q   <= {sclk_q[1:0], i_spi_clk};
      csn_q    <= {csn_q[1:0], i_spi_cs_n};
      mosi_q   <= {mosi_q[0], i_spi_mosi};
      samp_q   <= samp;
      mbit_q   <= mosi_q[1];
`ifdef SPI_SLAVE_MISO_EN
      shedge_q <= CPHA ? lead : trail;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      inc_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      is_rd_q   <= 1'b0;
      miso_q    <= 1'b0;
      pre_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      // post-write increment lands one cycle after the strobe
      if (inc_q) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        inc_q  <= 1'b0;
      end
`ifdef SPI_SLAVE_MISO_EN
      rd_en_q   <= 1'b0;
      rd_pend_q <= rd_en_q;
      if (rd_pend_q) pre_q <= i_mem_rdata;
`endif
      if (cs_rise) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        if (state_q == S_CMD || state_q == S_ADDR ||
            (state_q == S_WR_DATA && cnt_q != '0))
          err_q <= 1'b1;
`ifdef SPI_SLAVE_MISO_EN
        miso_q  <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cs_fall) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_CMD: begin
            if (samp_q) begin
              sh_q  <= {sh_q[SW-2:0], mbit_q};
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == CMD_LAST) begin
                cnt_q <= '0;
                if (cmd_w == CMD_WRITE) begin
                  state_q <= S_ADDR;
`ifdef SPI_SLAVE_MISO_EN
                  is_rd_q <= 1'b0;
                end else if (cmd_w == CMD_READ) begin
                  state_q <= S_ADDR;
                  is_rd_q <= 1'b1;
`endif
                end else begin
                  state_q <= S_DISCARD;
                  err_q   <= 1'b1;
                end
              end
            end
          end
          S_ADDR: begin
            if (samp_q) begin
              sh_q  <= {sh_q[SW-2:0], mbit_q};
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == ADDR_LAST) begin
                cnt_q   <= '0;
                addr_q  <= addr_w;
                state_q <= S_WR_DATA;
`ifdef SPI_SLAVE_MISO_EN
                if (is_rd_q) begin
                  state_q <= S_RD_TURN;
                  rd_en_q <= 1'b1;
                end
`endif
              end
            end
          end
          S_WR_DATA: begin
            if (samp_q) begin
              sh_q  <= {sh_q[SW-2:0], mbit_q};
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == DATA_LAST) begin
                cnt_q   <= '0;
                wdata_q <= data_w;
                wr_en_q <= 1'b1;
                inc_q   <= 1'b1;
              end
            end
          end
`ifdef SPI_SLAVE_MISO_EN
          S_RD_TURN: begin
            miso_q <= 1'b0;
            if (samp_q) begin
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == DATA_LAST) begin
                cnt_q   <= '0;
                state_q <= S_RD_DATA;
                sh_q    <= SW'(pre_q);
                addr_q  <= addr_q + ADDR_WIDTH'(1);
                rd_en_q <= 1'b1;
              end
            end
          end
          // the shift edge after each sample presents the next bit, so a
          // word loaded on the last sample appears MSB-first in time
          S_RD_DATA: begin
            if (shedge_q) begin
              miso_q <= sh_q[DATA_WIDTH-1];
              sh_q   <= sh_q << 1;
            end
            if (samp_q) begin
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == DATA_LAST) begin
                cnt_q   <= '0;
                sh_q    <= SW'(pre_q);
                addr_q  <= addr_q + ADDR_WIDTH'(1);
                rd_en_q <= 1'b1;
              end
            end
          end
`endif
          S_DISCARD: begin
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_mem_wr_en = wr_en_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = busy_q;
  assign o_frame_err = err_q;

`ifdef SPI_SLAVE_MISO_EN
  assign o_mem_rd_en   = rd_en_q;
  assign o_spi_miso    = miso_q;
  assign o_spi_miso_oe = busy_q;
`else
  assign o_mem_rd_en   = 1'b0;
  assign o_spi_miso    = 1'b0;
  assign o_spi_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_mem_bridge.sv
// Directed bench for spi_slave_mem_bridge: mode 0 default-width DUT and a
// mode 3, 16-bit data / 8-bit address DUT share the SPI bus, gated by CS.
module tb_spi_slave_mem_bridge;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sclk, mosi, cs;
  int   sel, cpol, cpha;

  logic        cs0, miso0, oe0, wr0, rd0, busy0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        cs3, miso3, oe3, wr3, rd3, busy3, err3;
  logic [7:0]  addr3;
  logic [15:0] wdata3;
  logic [15:0] rdata3;
  logic        miso_sel;

  assign cs0      = (sel == 0) ? cs : 1'b1;
  assign cs3      = (sel == 1) ? cs : 1'b1;
  assign miso_sel = (sel == 1) ? miso3 : miso0;
  assign rdata3   = '0;

  spi_slave_mem_bridge u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_spi_clk(sclk), .i_spi_mosi(mosi), .i_spi_cs_n(cs0),
    .o_spi_miso(miso0), .o_spi_miso_oe(oe0),
    .o_mem_wr_en(wr0), .o_mem_rd_en(rd0),
    .o_mem_addr(addr0), .o_mem_wdata(wdata0), .i_mem_rdata(rdata0),
    .o_busy(busy0), .o_frame_err(err0)
  );

  spi_slave_mem_bridge #(
    .SPI_MODE(3), .DATA_WIDTH(16), .ADDR_WIDTH(8)
  ) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_spi_clk(sclk), .i_spi_mosi(mosi), .i_spi_cs_n(cs3),
    .o_spi_miso(miso3), .o_spi_miso_oe(oe3),
    .o_mem_wr_en(wr3), .o_mem_rd_en(rd3),
    .o_mem_addr(addr3), .o_mem_wdata(wdata3), .i_mem_rdata(rdata3),
    .o_busy(busy3), .o_frame_err(err3)
  );

  // memory model: data valid only in the cycle after the read strobe
  always @(posedge clk) begin
    if (rd0)
      rdata0 <= (addr0 == 32'h20) ? 32'hCAFEF00D :
                (addr0 == 32'h21) ? 32'h0BADF00D : 32'h0;
    else
      rdata0 <= 32'h0;
  end

  logic [63:0] wa0[$], wd0[$], wa3[$], wd3[$];
  int nerr0, nerr3, nrd0, nboth, nwide, nmiso;
  logic err0_p, err3_p;

  always @(negedge clk) begin
    if (wr0) begin wa0.push_back(64'(addr0)); wd0.push_back(64'(wdata0)); end
    if (wr3) begin wa3.push_back(64'(addr3)); wd3.push_back(64'(wdata3)); end
    if (rd0) nrd0 <= nrd0 + 1;
    if (err0) nerr0 <= nerr0 + 1;
    if (err3) nerr3 <= nerr3 + 1;
    if ((wr0 && rd0) || (wr3 && rd3)) nboth <= nboth + 1;
    if ((err0 && err0_p) || (err3 && err3_p)) nwide <= nwide + 1;
`ifndef SPI_SLAVE_MISO_EN
    if (miso0 || oe0 || miso3 || oe3 || rd3) nmiso <= nmiso + 1;
`endif
    err0_p <= err0;
    err3_p <= err3;
  end

  int ntest = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    @(negedge clk);
    wa0.delete(); wd0.delete(); wa3.delete(); wd3.delete();
    nerr0 = 0; nerr3 = 0; nrd0 = 0;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    if (cpha == 0) begin
      mosi = b;
      repeat (HALF) @(negedge clk);
      sclk = ~cpol[0];
      r = miso_sel;
      repeat (HALF) @(negedge clk);
      sclk = cpol[0];
    end else begin
      sclk = ~cpol[0];
      mosi = b;
      repeat (HALF) @(negedge clk);
      sclk = cpol[0];
      r = miso_sel;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic spi_word(input logic [63:0] v, input int n,
                          output logic [63:0] r);
    logic b;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], b);
      r[i] = b;
    end
  endtask

  task automatic frame_start();
    sclk = cpol[0];
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  logic [63:0] rx, r1, r2, r3;

  initial begin
    sel = 0; cpol = 0; cpha = 0;
    sclk = 0; mosi = 0; cs = 1;
    nerr0 = 0; nerr3 = 0; nrd0 = 0; nboth = 0; nwide = 0; nmiso = 0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {60'h0, wr0, rd0, err0, busy0}, 64'h0);
    check("rst_addr", 64'(addr0), 64'h0);
    check("rst_wdata", 64'(wdata0), 64'h0);
    check("rst_miso", {62'h0, miso0, oe0}, 64'h0);
    check("rst_addr3", 64'(addr3), 64'h0);
    rst = 0;
    repeat (5) @(negedge clk);

    // mode 0 two-word burst
    clr();
    frame_start();
    spi_word(64'h02, 8, rx);
    spi_word(64'h10, 32, rx);
    check("t1_busy", 64'(busy0), 64'h1);
    spi_word(64'hDEADBEEF, 32, rx);
    spi_word(64'h12345678, 32, rx);
    frame_end();
    check("t1_nwr", 64'(wa0.size()), 64'd2);
    check("t1_a0", wa0[0], 64'h10);
    check("t1_d0", wd0[0], 64'hDEADBEEF);
    check("t1_a1", wa0[1], 64'h11);
    check("t1_d1", wd0[1], 64'h12345678);
    check("t1_err", 64'(nerr0), 64'd0);
    check("t1_idle", 64'(busy0), 64'h0);

    // mode 3, 16/8 widths, address wrap
    sel = 1; cpol = 1; cpha = 1; sclk = 1;
    repeat (10) @(negedge clk);
    clr();
    frame_start();
    spi_word(64'h02, 8, rx);
    spi_word(64'hFF, 8, rx);
    spi_word(64'h1234, 16, rx);
    spi_word(64'hABCD, 16, rx);
    spi_word(64'h0F0F, 16, rx);
    frame_end();
    check("t2_nwr", 64'(wa3.size()), 64'd3);
    check("t2_a0", wa3[0], 64'hFF);
    check("t2_d0", wd3[0], 64'h1234);
    check("t2_a1", wa3[1], 64'h00);
    check("t2_d1", wd3[1], 64'hABCD);
    check("t2_a2", wa3[2], 64'h01);
    check("t2_d2", wd3[2], 64'h0F0F);
    check("t2_err", 64'(nerr3), 64'd0);
    sel = 0; cpol = 0; cpha = 0; sclk = 0;
    repeat (10) @(negedge clk);

    // CS raised 20 bits into the second word
    clr();
    frame_start();
    spi_word(64'h02, 8, rx);
    spi_word(64'h40, 32, rx);
    spi_word(64'h11111111, 32, rx);
    spi_word(64'h22222, 20, rx);
    frame_end();
    check("t3_nwr", 64'(wa0.size()), 64'd1);
    check("t3_a0", wa0[0], 64'h40);
    check("t3_d0", wd0[0], 64'h11111111);
    check("t3_err", 64'(nerr0), 64'd1);
    clr();
    frame_start();
    spi_word(64'h02, 8, rx);
    spi_word(64'h50, 32, rx);
    spi_word(64'hA5A5A5A5, 32, rx);
    frame_end();
    check("t3b_nwr", 64'(wa0.size()), 64'd1);
    check("t3b_a0", wa0[0], 64'h50);
    check("t3b_d0", wd0[0], 64'hA5A5A5A5);
    check("t3b_err", 64'(nerr0), 64'd0);

    // invalid command
    clr();
    frame_start();
    spi_word(64'hA5, 8, rx);
    spi_word(64'h02_0000_0010, 40, rx);
    spi_word(64'hFFFFFFFF, 32, rx);
    frame_end();
    check("t4_err", 64'(nerr0), 64'd1);
    check("t4_nwr", 64'(wa0.size()), 64'd0);
    check("t4_nrd", 64'(nrd0), 64'd0);

`ifdef SPI_SLAVE_MISO_EN
    // readback with one dummy word
    clr();
    frame_start();
    spi_word(64'h03, 8, rx);
    check("t5_oe", 64'(oe0), 64'h1);
    spi_word(64'h20, 32, rx);
    spi_word(64'h0, 32, r1);
    spi_word(64'h0, 32, r2);
    spi_word(64'h0, 32, r3);
    frame_end();
    check("t5_w0", r1, 64'h0);
    check("t5_w1", r2, 64'hCAFEF00D);
    check("t5_w2", r3, 64'h0BADF00D);
    check("t5_err", 64'(nerr0), 64'd0);
    check("t5_nwr", 64'(wa0.size()), 64'd0);
    check("t5_oe_off", 64'(oe0), 64'h0);
`else
    // READ is invalid without MISO support
    clr();
    frame_start();
    spi_word(64'h03, 8, rx);
    spi_word(64'h20, 32, rx);
    spi_word(64'h0, 32, r1);
    frame_end();
    check("t5_err", 64'(nerr0), 64'd1);
    check("t5_nrd", 64'(nrd0), 64'd0);
    check("t5_miso", r1, 64'h0);
    check("t5_nmiso", 64'(nmiso), 64'd0);
`endif

    // reset mid address phase
    clr();
    frame_start();
    spi_word(64'h02, 8, rx);
    spi_word(64'h123, 12, rx);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out", {60'h0, wr0, rd0, err0, busy0}, 64'h0);
    check("t6_rst_addr", 64'(addr0), 64'h0);
    check("t6_rst_wd", 64'(wdata0), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    spi_word(64'h45678, 20, rx);
    spi_word(64'h55555555, 32, rx);
    check("t6_busy", 64'(busy0), 64'h0);
    frame_end();
    check("t6_nwr", 64'(wa0.size()), 64'd0);
    check("t6_err", 64'(nerr0), 64'd0);
    clr();
    frame_start();
    spi_word(64'h02, 8, rx);
    spi_word(64'h60, 32, rx);
    spi_word(64'h0000C0DE, 32, rx);
    frame_end();
    check("t6b_nwr", 64'(wa0.size()), 64'd1);
    check("t6b_a0", wa0[0], 64'h60);
    check("t6b_d0", wd0[0], 64'h0000C0DE);

    check("both_strobes", 64'(nboth), 64'd0);
    check("err_width", 64'(nwide), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
